// File: rtl/serial_digit_adder.sv
// Multi-cycle adder/subtractor: one DIGIT-bit ripple slice per cycle with the
// inter-slice carry held in a register, valid/ready handshake on both sides.
module serial_digit_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  if ((WIDTH % DIGIT) != 0) begin : gen_param_check
    $error("serial_digit_adder: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_out_q, carry_out_d;
  logic              overflow_q, overflow_d;

  logic [DIGIT-1:0]  dig_a, dig_b, dig_s;
  logic [DIGIT:0]    chain;
  int unsigned       base;

  // Ripple chain over the current digit; chain[DIGIT-1] is the carry into its MSB.
  always_comb begin
    base     = 32'(idx_q) * DIGIT;
    dig_a    = a_q[base +: DIGIT];
    dig_b    = b_q[base +: DIGIT];
    dig_s    = '0;
    chain    = '0;
    chain[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      dig_s[i]     = dig_a[i] ^ dig_b[i] ^ chain[i];
      chain[i + 1] = (dig_a[i] & dig_b[i]) | (chain[i] & (dig_a[i] ^ dig_b[i]));
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : carry_in;
          idx_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        sum_d[base +: DIGIT] = dig_s;
        carry_d              = chain[DIGIT];
        idx_d                = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          carry_out_d = chain[DIGIT];
          overflow_d  = chain[DIGIT-1] ^ chain[DIGIT];
          idx_d       = '0;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Bench for serial_digit_adder: whole-word arithmetic model checked every cycle,
// directed literal cases, backpressure, mid-operation reset and DIGIT=1/16 variants.
module tb_serial_digit_adder;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          carry_in = 1'b0;
  logic          sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          carry_out;
  logic          overflow;

  // Secondary instances with other digit sizes, always ready downstream.
  logic          iv_x = 1'b0;
  logic          ro_x = 1'b1;
  logic          ir1, ov1v, co1, of1, ir16, ov16v, co16, of16;
  logic [W-1:0]  s1, s16;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_digit_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  serial_digit_adder #(.WIDTH(16), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(ir1),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(ov1v), .out_ready(ro_x),
    .sum(s1), .carry_out(co1), .overflow(of1)
  );

  serial_digit_adder #(.WIDTH(16), .DIGIT(16)) dut_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(ir16),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(ov16v), .out_ready(ro_x),
    .sum(s16), .carry_out(co16), .overflow(of16)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: whole-word arithmetic, a latency countdown and the visible outputs.
  typedef enum {MIdle, MBusy, MDone} mst_t;
  mst_t         m_st = MIdle;
  int           m_left = 0;
  logic [W-1:0] m_sum = '0, p_sum = '0;
  logic         m_co = 1'b0, m_ov = 1'b0, p_co = 1'b0, p_ov = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] be;
    logic [W:0]   full;
    if (!rst_n) begin
      m_st  = MIdle;
      m_sum = '0;
      m_co  = 1'b0;
      m_ov  = 1'b0;
    end else begin
      case (m_st)
        MIdle: if (in_valid) begin
          be     = sub ? ~b : b;
          full   = {1'b0, a} + {1'b0, be} + (W+1)'(sub ? 1'b1 : carry_in);
          p_sum  = full[W-1:0];
          p_co   = full[W];
          p_ov   = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
          m_left = N;
          m_st   = MBusy;
        end
        MBusy: begin
          m_left--;
          if (m_left == 0) begin
            m_sum = p_sum;
            m_co  = p_co;
            m_ov  = p_ov;
            m_st  = MDone;
          end
        end
        default: if (out_ready) m_st = MIdle;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model in_ready", in_ready, m_st == MIdle);
      check("model out_valid", out_valid, m_st == MDone);
      if (m_st != MBusy) begin
        check("model sum", sum, m_sum);
        check("model carry_out", carry_out, m_co);
        check("model overflow", overflow, m_ov);
      end
    end
  end

  // One operation on the DIGIT=4 instance with literal expectations.
  task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic ts, input logic [W-1:0] es,
                       input logic eco, input logic eov, input int hold);
    int lat;
    check({nm, " idle before"}, in_ready, 1'b1);
    a = ta; b = tb; carry_in = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; carry_in = $urandom; sub = $urandom;
    lat = 0;
    while (!out_valid && lat < 40) begin
      check({nm, " in_ready busy"}, in_ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, lat, N);
    check({nm, " sum"}, sum, es);
    check({nm, " carry_out"}, carry_out, eco);
    check({nm, " overflow"}, overflow, eov);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom;
      @(negedge clk);
      check({nm, " hold out_valid"}, out_valid, 1'b1);
      check({nm, " hold in_ready"}, in_ready, 1'b0);
      check({nm, " hold sum"}, sum, es);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, " back to idle"}, in_ready, 1'b1);
    check({nm, " out_valid drop"}, out_valid, 1'b0);
  endtask

  initial begin
    int lat1, lat16, cyc;
    logic [W-1:0] corners [4];
    corners[0] = 16'h0000; corners[1] = 16'hFFFF; corners[2] = 16'h7FFF; corners[3] = 16'h8000;

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset sum", sum, 16'h0000);
    check("reset carry_out", carry_out, 1'b0);
    check("reset overflow", overflow, 1'b0);

    do_op("t1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    do_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    do_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    do_op("t3b", 16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0);
    do_op("t4a", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    do_op("t4b", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 0);
    do_op("t5", 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0, 3);

    // Reset after E2 of an operation: everything cleared, no result ever appears.
    a = 16'hFFFF; b = 16'h0001; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6 in_ready", in_ready, 1'b1);
    check("t6 out_valid", out_valid, 1'b0);
    check("t6 sum", sum, 16'h0000);
    check("t6 carry_out", carry_out, 1'b0);
    check("t6 overflow", overflow, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6 no result", out_valid, 1'b0);
    end

    // Scenario 2 on DIGIT=1 and DIGIT=16.
    check("x d1 idle", ir1, 1'b1);
    check("x d16 idle", ir16, 1'b1);
    a = 16'hFFFF; b = 16'h0001; carry_in = 1'b0; sub = 1'b0; iv_x = 1'b1;
    @(negedge clk);
    iv_x = 1'b0;
    lat1 = -1; lat16 = -1;
    for (int c = 1; c <= 30; c++) begin
      if (ov16v && lat16 < 0) begin
        lat16 = c - 1;
        check("x d16 sum", s16, 16'h0000);
        check("x d16 carry_out", co16, 1'b1);
        check("x d16 overflow", of16, 1'b0);
      end
      if (ov1v && lat1 < 0) begin
        lat1 = c - 1;
        check("x d1 sum", s1, 16'h0000);
        check("x d1 carry_out", co1, 1'b1);
        check("x d1 overflow", of1, 1'b0);
      end
      @(negedge clk);
    end
    check("x d1 latency", lat1, 16);
    check("x d16 latency", lat16, 1);

    // Randomised traffic, checked every cycle by the model compare process.
    for (cyc = 0; cyc < 3000; cyc++) begin
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
      carry_in  = 1'($urandom);
      sub       = 1'($urandom);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 5);
      rst_n     = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
